mem_port_arbiter: RTL and testbench

Shares the single-port 64-bit data memory of the multicycle MIPS core between two requesters: the CPU load/store path and the debug/inspection port that the simulation bench uses to peek memory contents. The arbiter is a registered request/acknowledge sequencer. It grants one requester at a time, drives the memory port, waits the memory's fixed read latency, and returns read data with a one-cycle acknowledge. It sits between the core's `top` and the memory instance.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port 64-bit data memory between the
// CPU load/store path and the debug peek port. One requester is granted at a
// time; the access is issued for one cycle, reads wait out the fixed memory
// latency, and completion is signalled with a one-cycle registered ack.
//
// Handshake: a requester raises req and holds it, with its command stable,
// until it sees its ack. ack is high for exactly one cycle. Command inputs are
// captured on the grant edge, so they may change afterwards. A req still high
// in the cycle after ack is taken as a fresh request.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int DBG_AW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_we,
    input  logic [63:0]       cpu_adr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic [DBG_AW-1:0] dbg_adr,
    output logic [63:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic [1:0]        mem_we,
    output logic [63:0]       mem_adr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);
    localparam int         PAD_W    = 64 - DBG_AW - 3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    // Side granted most recently; during a transaction it is also the side being served.
    logic        last_grant_q, last_grant_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic [63:0] cpu_rdata_q, cpu_rdata_d;
    logic [63:0] dbg_rdata_q, dbg_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic [1:0]  mem_we_q, mem_we_d;
    logic [63:0] mem_adr_q, mem_adr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        grant_dbg;

    // Next-state logic: arbitration in IDLE, issue, latency count and response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        cpu_ack_d    = 1'b0;
        dbg_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 2'b00;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_dbg    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On a tie the side that was not served last wins.
                    grant_dbg    = dbg_req && (!cpu_req || (last_grant_q == GNT_CPU));
                    state_d      = S_ISSUE;
                    last_grant_d = grant_dbg ? GNT_DBG : GNT_CPU;
                    mem_en_d     = 1'b1;
                    if (grant_dbg) begin
                        mem_we_d  = 2'b00;
                        mem_adr_d = {{PAD_W{1'b0}}, dbg_adr, 3'b000};
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_adr_d   = cpu_adr;
                        mem_wdata_d = cpu_wdata;
                    end
                end
            end
            S_ISSUE: begin
                // mem_we_q still holds the latched command during ISSUE.
                if (mem_we_q != 2'b00) begin
                    state_d   = S_RESP;
                    cpu_ack_d = (last_grant_q == GNT_CPU);
                    dbg_ack_d = (last_grant_q == GNT_DBG);
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                    if (last_grant_q == GNT_DBG) begin
                        dbg_rdata_d = mem_rdata;
                        dbg_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= GNT_DBG;
            cpu_ack_q    <= 1'b0;
            dbg_ack_q    <= 1'b0;
            cpu_rdata_q  <= 64'd0;
            dbg_rdata_q  <= 64'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 2'b00;
            mem_adr_q    <= 64'd0;
            mem_wdata_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            cpu_ack_q    <= cpu_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (memory latency 1 and 3), each
// with a behavioural memory, driven by directed and randomized transactions.
module tb_mem_port_arbiter;

    localparam int DBG_AW = 8;
    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic reset;

    // Instance with MEM_LAT = 1
    logic              cpu_req, dbg_req, cpu_ack, dbg_ack, mem_en, busy;
    logic [1:0]        cpu_we, mem_we, fsm_state;
    logic [63:0]       cpu_adr, cpu_wdata, cpu_rdata, dbg_rdata;
    logic [63:0]       mem_adr, mem_wdata, mem_rdata;
    logic [DBG_AW-1:0] dbg_adr;

    // Instance with MEM_LAT = 3 (CPU side only)
    logic              cpu_req_3, dbg_req_3, cpu_ack_3, dbg_ack_3, mem_en_3, busy_3;
    logic [1:0]        cpu_we_3, mem_we_3, fsm_state_3;
    logic [63:0]       cpu_adr_3, cpu_wdata_3, cpu_rdata_3, dbg_rdata_3;
    logic [63:0]       mem_adr_3, mem_wdata_3, mem_rdata_3;
    logic [DBG_AW-1:0] dbg_adr_3;

    mem_port_arbiter #(.MEM_LAT(1), .DBG_AW(DBG_AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .fsm_state(fsm_state)
    );

    mem_port_arbiter #(.MEM_LAT(3), .DBG_AW(DBG_AW)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_adr(cpu_adr_3), .cpu_wdata(cpu_wdata_3),
        .cpu_rdata(cpu_rdata_3), .cpu_ack(cpu_ack_3),
        .dbg_req(dbg_req_3), .dbg_adr(dbg_adr_3), .dbg_rdata(dbg_rdata_3), .dbg_ack(dbg_ack_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_adr(mem_adr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3), .fsm_state(fsm_state_3)
    );

    // ---------------- memories ----------------
    function automatic logic [63:0] init_val(longint idx);
        return (64'(idx) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] f3(logic [63:0] a);
        return {a[31:0], a[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    logic [63:0] phys [longint];
    logic [63:0] ref_mem [longint];

    function automatic logic [63:0] phys_rd(longint idx);
        if (phys.exists(idx)) return phys[idx];
        return init_val(idx);
    endfunction

    function automatic logic [63:0] ref_rd(longint idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return init_val(idx);
    endfunction

    logic [63:0] pipe1 [0:6] = '{default: GARBAGE};
    logic [63:0] pipe3 [0:6] = '{default: GARBAGE};

    // Memory for the latency-1 instance: reads appear 1 cycle after the strobe,
    // garbage otherwise. Only full 64-bit writes are exercised.
    always @(posedge clk) begin
        pipe1[0] <= (mem_en && mem_we == 2'b00) ? phys_rd(longint'(mem_adr >> 3)) : GARBAGE;
        for (int i = 1; i < 7; i++) pipe1[i] <= pipe1[i-1];
        if (mem_en && mem_we != 2'b00) phys[longint'(mem_adr >> 3)] = mem_wdata;
    end
    assign mem_rdata = pipe1[0];

    // Memory for the latency-3 instance: read data is a fixed function of address.
    always @(posedge clk) begin
        pipe3[0] <= (mem_en_3 && mem_we_3 == 2'b00) ? f3(mem_adr_3) : GARBAGE;
        for (int i = 1; i < 7; i++) pipe3[i] <= pipe3[i-1];
    end
    assign mem_rdata_3 = pipe3[2];

    // ---------------- reference state ----------------
    logic        model_last;     // 1 = debug served last
    logic [63:0] exp_cpu_rdata;
    logic [63:0] exp_q [$];

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- driver ----------------
    int          obs_ack_cyc;
    logic [63:0] obs_rdata, obs_cpu_rd, obs_adr, obs_wd;
    logic        obs_en, obs_en2, obs_other;
    logic [1:0]  obs_we;

    // Called one time unit after a rising edge with the arbiter idle. Cycle 0 is
    // the cycle whose closing edge samples the request.
    task automatic txn1(input bit is_dbg, input logic [1:0] we, input logic [63:0] adr,
                        input logic [63:0] wd, input logic [DBG_AW-1:0] dadr);
        obs_ack_cyc = -1; obs_other = 1'b0; obs_en = 1'b0; obs_en2 = 1'b1;
        obs_adr = '0; obs_wd = '0; obs_we = 2'b11; obs_rdata = '0; obs_cpu_rd = '0;
        if (is_dbg) begin
            dbg_adr = dadr; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_adr = adr; cpu_wdata = wd; cpu_req = 1'b1;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                obs_en = mem_en; obs_adr = mem_adr; obs_we = mem_we; obs_wd = mem_wdata;
                // Command changes after the grant must be ignored.
                cpu_adr = r64(); cpu_wdata = r64(); cpu_we = 2'($urandom());
                dbg_adr = DBG_AW'($urandom());
            end
            if (c == 2) obs_en2 = mem_en;
            if (is_dbg ? cpu_ack : dbg_ack) obs_other = 1'b1;
            if (is_dbg ? dbg_ack : cpu_ack) begin
                obs_ack_cyc = c;
                obs_rdata   = is_dbg ? dbg_rdata : cpu_rdata;
                obs_cpu_rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int          found;
        logic        first_dbg;
        reset = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1;
        cpu_we = 2'b00; cpu_adr = 64'd64; dbg_adr = 8'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cpu_ack, dbg_ack, mem_en, busy, mem_we} !== 6'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {cpu_ack, dbg_ack, mem_en, busy, mem_we});
        end
        n_cmp++;
        if ({mem_adr, mem_wdata} !== 128'd0) begin
            n_err++; $display("FAIL reset_mem: got adr %0h wdata %0h want 0", mem_adr, mem_wdata);
        end
        n_cmp++;
        if ({cpu_rdata, dbg_rdata} !== 128'd0) begin
            n_err++; $display("FAIL reset_rdata: got %0h/%0h want 0", cpu_rdata, dbg_rdata);
        end
        n_cmp++;
        if (busy_3 !== 1'b0) begin
            n_err++; $display("FAIL reset_busy3: got %b want 0", busy_3);
        end
        @(posedge clk); #1 reset = 1'b1;
        found = -1; first_dbg = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) begin
                found = c; first_dbg = dbg_ack;
                break;
            end
        end
        cpu_req = 1'b0;
        n_cmp++;
        if (found != 3 || first_dbg !== 1'b0) begin
            n_err++; $display("FAIL reset_first_grant: got cycle %0d dbg=%b want cycle 3 cpu", found, first_dbg);
        end
        n_cmp++;
        if (cpu_rdata !== ref_rd(8)) begin
            n_err++; $display("FAIL reset_first_data: got %0h want %0h", cpu_rdata, ref_rd(8));
        end
        exp_cpu_rdata = ref_rd(8);
        found = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dbg_ack) begin
                found = c;
                break;
            end
        end
        dbg_req = 1'b0;
        n_cmp++;
        if (found < 0 || dbg_rdata !== ref_rd(3)) begin
            n_err++; $display("FAIL reset_second_grant: got cycle %0d data %0h want dbg data %0h", found, dbg_rdata, ref_rd(3));
        end
        model_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write();
        txn1(1'b0, 2'b10, 64'd84, 64'd7, '0);
        ref_mem[10] = 64'd7;
        model_last = 1'b0;
        n_cmp++;
        if ({obs_en, obs_we} !== 3'b110 || obs_adr !== 64'd84 || obs_wd !== 64'd7) begin
            n_err++; $display("FAIL cpu_write_issue: got en %b we %b adr %0d wdata %0h want 1 10 84 7", obs_en, obs_we, obs_adr, obs_wd);
        end
        n_cmp++;
        if (obs_ack_cyc != 2 || obs_other !== 1'b0) begin
            n_err++; $display("FAIL cpu_write_ack: got cycle %0d other %b want 2 0", obs_ack_cyc, obs_other);
        end
        n_cmp++;
        if (obs_en2 !== 1'b0 || obs_cpu_rd !== exp_cpu_rdata) begin
            n_err++; $display("FAIL cpu_write_side: got en2 %b rdata %0h want 0 %0h", obs_en2, obs_cpu_rd, exp_cpu_rdata);
        end
    endtask

    task automatic test_cpu_read();
        phys[16] = 64'd7; ref_mem[16] = 64'd7;
        txn1(1'b0, 2'b00, 64'd128, r64(), '0);
        model_last = 1'b0;
        exp_cpu_rdata = 64'd7;
        n_cmp++;
        if (obs_ack_cyc != 3 || obs_rdata !== 64'd7 || obs_other !== 1'b0) begin
            n_err++; $display("FAIL cpu_read: got cycle %0d data %0h dbg_ack %b want 3 7 0", obs_ack_cyc, obs_rdata, obs_other);
        end
        n_cmp++;
        if (obs_adr !== 64'd128 || obs_we !== 2'b00) begin
            n_err++; $display("FAIL cpu_read_issue: got adr %0d we %b want 128 00", obs_adr, obs_we);
        end
    endtask

    task automatic test_dbg_read();
        txn1(1'b1, 2'b00, '0, '0, 8'd10);
        model_last = 1'b1;
        n_cmp++;
        if (obs_adr !== 64'd80 || obs_we !== 2'b00 || obs_en !== 1'b1) begin
            n_err++; $display("FAIL dbg_read_issue: got adr %0d we %b en %b want 80 00 1", obs_adr, obs_we, obs_en);
        end
        n_cmp++;
        if (obs_ack_cyc != 3 || obs_rdata !== ref_rd(10) || obs_other !== 1'b0) begin
            n_err++; $display("FAIL dbg_read: got cycle %0d data %0h want 3 %0h", obs_ack_cyc, obs_rdata, ref_rd(10));
        end
        n_cmp++;
        if (obs_cpu_rd !== exp_cpu_rdata) begin
            n_err++; $display("FAIL dbg_read_cpu_hold: got %0h want %0h", obs_cpu_rd, exp_cpu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int          n;
        int          side [4];
        int          cyc [4];
        logic [63:0] dat [4];
        logic        busy_h [0:79];
        logic [63:0] a;
        logic [DBG_AW-1:0] d;
        logic        exp_side;
        a = 64'($urandom_range(0, 31)) << 3;
        d = DBG_AW'($urandom_range(32, 63));
        n = 0;
        cpu_we = 2'b00; cpu_adr = a; dbg_adr = d; cpu_req = 1'b1; dbg_req = 1'b1;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            busy_h[c] = busy;
            if (cpu_ack || dbg_ack) begin
                side[n] = (cpu_ack && dbg_ack) ? 2 : (dbg_ack ? 1 : 0);
                cyc[n] = c;
                dat[n] = dbg_ack ? dbg_rdata : cpu_rdata;
                n++;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (n != 4) begin
            n_err++; $display("FAIL b2b_count: got %0d acks want 4", n);
        end
        for (int k = 0; k < n; k++) begin
            exp_side = (k % 2 == 0) ? !model_last : model_last;
            n_cmp++;
            if (side[k] != int'(exp_side)) begin
                n_err++; $display("FAIL b2b_order[%0d]: got side %0d want %0d", k, side[k], exp_side);
            end
            n_cmp++;
            if (dat[k] !== (exp_side ? ref_rd(longint'(d)) : ref_rd(longint'(a >> 3)))) begin
                n_err++; $display("FAIL b2b_data[%0d]: got %0h", k, dat[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if (cyc[k] - cyc[k-1] != 4) begin
                    n_err++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 4", k, cyc[k] - cyc[k-1]);
                end
            end
            if (k < n - 1) begin
                n_cmp++;
                if (busy_h[cyc[k] + 1] !== 1'b0 || busy_h[cyc[k] + 2] !== 1'b1) begin
                    n_err++; $display("FAIL b2b_idle[%0d]: got busy %b%b want 01", k, busy_h[cyc[k] + 1], busy_h[cyc[k] + 2]);
                end
            end
        end
        exp_cpu_rdata = ref_rd(longint'(a >> 3));
    endtask

    task automatic test_random();
        bit          is_dbg;
        int          idx;
        logic [1:0]  we;
        logic [63:0] wd;
        logic [63:0] e;
        for (int it = 0; it < 24; it++) begin
            is_dbg = 1'($urandom_range(0, 1));
            idx    = $urandom_range(0, 15);
            case ($urandom_range(0, 2))
                0:       we = 2'b00;
                1:       we = 2'b10;
                default: we = 2'b11;
            endcase
            if (is_dbg) we = 2'b00;
            wd = r64();
            if (we == 2'b00) exp_q.push_back(ref_rd(idx));
            txn1(is_dbg, we, 64'(idx) << 3, wd, DBG_AW'(idx));
            model_last = is_dbg;
            n_cmp++;
            if (obs_ack_cyc != ((we == 2'b00) ? 3 : 2) || obs_other !== 1'b0 || obs_adr !== (64'(idx) << 3)) begin
                n_err++; $display("FAIL rand_txn[%0d]: got cycle %0d other %b adr %0h", it, obs_ack_cyc, obs_other, obs_adr);
            end
            if (we == 2'b00) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs_rdata !== e) begin
                    n_err++; $display("FAIL rand_read[%0d]: got %0h want %0h", it, obs_rdata, e);
                end
                if (!is_dbg) exp_cpu_rdata = e;
            end else begin
                ref_mem[idx] = wd;
                n_cmp++;
                if (obs_cpu_rd !== exp_cpu_rdata) begin
                    n_err++; $display("FAIL rand_write_hold[%0d]: got %0h want %0h", it, obs_cpu_rd, exp_cpu_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        cpu_we = 2'b00; cpu_adr = 64'd40; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            n_err++; $display("FAIL rst_wait_state: got busy %b en %b want 1 0", busy, mem_en);
        end
        reset = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (cpu_ack !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rst_wait_abort[%0d]: got ack %b busy %b want 0 0", c, cpu_ack, busy);
            end
        end
        n_cmp++;
        if (cpu_rdata !== 64'd0) begin
            n_err++; $display("FAIL rst_wait_rdata: got %0h want 0", cpu_rdata);
        end
        exp_cpu_rdata = 64'd0;
        model_last = 1'b1;
        @(posedge clk); #1;
        txn1(1'b0, 2'b00, 64'd40, '0, '0);
        model_last = 1'b0;
        n_cmp++;
        if (obs_ack_cyc != 3 || obs_rdata !== ref_rd(5)) begin
            n_err++; $display("FAIL rst_wait_retry: got cycle %0d data %0h want 3 %0h", obs_ack_cyc, obs_rdata, ref_rd(5));
        end
    endtask

    task automatic test_lat3();
        int          found;
        logic [63:0] a, d, cap_adr;
        logic        cap_en;
        logic [1:0]  we;
        for (int it = 0; it < 4; it++) begin
            a  = r64() & ~64'd7;
            we = (it == 2) ? 2'b11 : 2'b00;
            cpu_we_3 = we; cpu_adr_3 = a; cpu_wdata_3 = r64(); cpu_req_3 = 1'b1;
            found = -1; d = '0; cap_adr = '0; cap_en = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    cap_en = mem_en_3; cap_adr = mem_adr_3;
                end
                if (cpu_ack_3) begin
                    found = c; d = cpu_rdata_3;
                    break;
                end
            end
            cpu_req_3 = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (found != ((we == 2'b00) ? 5 : 2) || cap_en !== 1'b1 || cap_adr !== a) begin
                n_err++; $display("FAIL lat3_txn[%0d]: got cycle %0d en %b adr %0h", it, found, cap_en, cap_adr);
            end
            if (we == 2'b00) begin
                n_cmp++;
                if (d !== f3(a)) begin
                    n_err++; $display("FAIL lat3_data[%0d]: got %0h want %0h", it, d, f3(a));
                end
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 2'b00; cpu_adr = '0; cpu_wdata = '0; dbg_adr = '0;
        cpu_req_3 = 1'b0; dbg_req_3 = 1'b0; cpu_we_3 = 2'b00; cpu_adr_3 = '0; cpu_wdata_3 = '0; dbg_adr_3 = '0;
        model_last = 1'b1;
        exp_cpu_rdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_dbg_read();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        test_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
